gslcd_v1_0_pixel_out: RTL and testbench
=======================================

GSLCD_V1_0_PIXEL_OUT -- requirements
Module: gslcd_v1_0_pixel_out

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 24, meaning pixel word width (8:8:8 R:G:B, R in MSBs).
REQ-002 SHALL have parameter C_UNDERFLOW_CNT_WIDTH, default 16, meaning underflow event counter width.
REQ-003 SHALL have parameter C_BAR_WIDTH, default 100, meaning test-pattern bar width in pixels.
REQ-004 SHALL have ports: PCLK in 1 pixel clock; RESETN in 1 reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: EN in 1 enable; VSYNC_IN, HSYNC_IN, ACTIVE_IN, RD_ACTIVE_IN, FRAME_START_IN in 1 each, from the timing generator.
REQ-006 SHALL have ports: FIFO_DATA in C_DATA_WIDTH; FIFO_EMPTY in 1; FIFO_RD_EN out 1 (standard FIFO, data valid one cycle after FIFO_RD_EN).
REQ-007 SHALL have ports: LCD_DATA out C_DATA_WIDTH; LCD_VSYNC, LCD_HSYNC, LCD_DE out 1 each.
REQ-008 SHALL have ports: UNDERFLOW out 1 sticky flag; UNDERFLOW_CNT out C_UNDERFLOW_CNT_WIDTH; UNDERFLOW_CLR in 1; FRAME_SYNC out 1; TEST_PATTERN in 1.

Function
REQ-009 SHALL implement states IDLE, WAIT_FRAME, RUN, BLANK.
REQ-010 SHALL go to IDLE from any state whenever EN=0; IDLE -> WAIT_FRAME when EN=1.
REQ-011 SHALL go WAIT_FRAME -> RUN and BLANK -> RUN on the cycle FRAME_START_IN rises (0->1, registered edge detect).
REQ-012 SHALL drive FIFO_RD_EN combinationally = RD_ACTIVE_IN & state==RUN & !FIFO_EMPTY & !test-pattern-active.
REQ-013 SHALL declare underflow when state==RUN, RD_ACTIVE_IN=1, FIFO_EMPTY=1 (test pattern inactive): next state BLANK, FIFO_RD_EN=0 that cycle.
REQ-014 SHALL register outputs once: LCD_DE, LCD_VSYNC, LCD_HSYNC = ACTIVE_IN, VSYNC_IN, HSYNC_IN delayed exactly 1 PCLK.
REQ-015 SHALL register LCD_DATA <= FIFO_DATA when ACTIVE_IN=1 and a read was issued the previous cycle; otherwise LCD_DATA <= 0.
REQ-016 SHALL output LCD_DATA=0 (black) with syncs and LCD_DE still toggling in WAIT_FRAME and BLANK; all LCD outputs 0 in IDLE.
REQ-017 SHALL set UNDERFLOW=1 on each underflow event; clear on UNDERFLOW_CLR=1; set wins if both same cycle.
REQ-018 SHALL increment UNDERFLOW_CNT once per underflow event (not per pixel), saturating at all-ones; UNDERFLOW_CLR does not clear the counter.
REQ-019 SHALL pulse FRAME_SYNC high exactly 1 cycle on each FRAME_START_IN rising edge while EN=1, for upstream DMA restart.
REQ-020 SHALL treat RD_ACTIVE_IN as leading ACTIVE_IN by one cycle; no further alignment logic.

Reset
REQ-021 SHALL, with RESETN=0, asynchronously force state IDLE, all outputs 0, UNDERFLOW_CNT 0, edge-detect register 0.
REQ-022 SHALL leave reset synchronously to PCLK; first FRAME_START_IN high after reset with EN=1 counts as a rising edge.
REQ-023 SHALL, on reset mid-line, not issue FIFO_RD_EN until the next FRAME_START_IN rising edge after deassertion.

Configuration
REQ-024 SHALL compile test-pattern logic only when macro GSLCD_TEST_PATTERN_EN is defined.
REQ-025 SHALL, with GSLCD_TEST_PATTERN_EN defined and TEST_PATTERN=1 in RUN, output 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black, each C_BAR_WIDTH active pixels, column counter reset on ACTIVE_IN falling), FIFO_RD_EN=0, no underflow.
REQ-026 SHALL, without GSLCD_TEST_PATTERN_EN, keep TEST_PATTERN port present but ignored.
REQ-027 SHALL sample TEST_PATTERN only on FRAME_START_IN rising edge (no mid-frame switching).

Verification
REQ-028 Normal frame: FIFO never empty, ramp data 0,1,2... -> LCD_DE = ACTIVE_IN delayed 1, first active LCD_DATA=0, increments per pixel, FIFO_RD_EN count = active pixels.
REQ-029 Underflow: FIFO_EMPTY=1 at 10th active pixel of line 50 -> UNDERFLOW=1, UNDERFLOW_CNT=1, LCD_DATA=0 rest of frame, FIFO_RD_EN=0 until next FRAME_START_IN rise, then RUN.
REQ-030 Saturation/clear: force 2^16+3 underflow events with C_UNDERFLOW_CNT_WIDTH=16 -> UNDERFLOW_CNT=0xFFFF; UNDERFLOW_CLR and event same cycle -> UNDERFLOW stays 1.
REQ-031 Reset mid-line (RESETN low 3 cycles during active pixel 200) -> outputs 0 immediately; no FIFO_RD_EN until next FRAME_START_IN rise; FRAME_SYNC single 1-cycle pulse there.
REQ-032 EN drop mid-frame -> IDLE next cycle, LCD outputs 0; EN=1 again -> WAIT_FRAME, RUN on next frame start.
REQ-033 With GSLCD_TEST_PATTERN_EN, TEST_PATTERN=1, C_BAR_WIDTH=100 -> active pixel 0 = 0xFFFFFF, pixel 100 = 0xFFFF00, pixel 700 = 0x000000, FIFO_RD_EN never 1.

Source files
------------

// File: rtl/gslcd_v1_0_pixel_out.sv
// gslcd_v1_0_pixel_out: pixel output stage of the LCD controller.
// Pulls pixels from the line FIFO while the timing generator reports a read
// window. It delays the syncs and data enable by one PCLK, blanks to black
// after a FIFO underflow until the next frame start, and keeps a sticky
// underflow flag plus a saturating event counter.
// Optional colour-bar test pattern is compiled in when GSLCD_TEST_PATTERN_EN
// is defined; otherwise TEST_PATTERN is accepted but has no effect.
module gslcd_v1_0_pixel_out #(
    parameter int C_DATA_WIDTH          = 24,
    parameter int C_UNDERFLOW_CNT_WIDTH = 16,
    parameter int C_BAR_WIDTH           = 100
) (
    input  logic                             PCLK,
    input  logic                             RESETN,
    input  logic                             EN,
    input  logic                             VSYNC_IN,
    input  logic                             HSYNC_IN,
    input  logic                             ACTIVE_IN,
    input  logic                             RD_ACTIVE_IN,
    input  logic                             FRAME_START_IN,
    input  logic [C_DATA_WIDTH-1:0]          FIFO_DATA,
    input  logic                             FIFO_EMPTY,
    output logic                             FIFO_RD_EN,
    output logic [C_DATA_WIDTH-1:0]          LCD_DATA,
    output logic                             LCD_VSYNC,
    output logic                             LCD_HSYNC,
    output logic                             LCD_DE,
    output logic                             UNDERFLOW,
    output logic [C_UNDERFLOW_CNT_WIDTH-1:0] UNDERFLOW_CNT,
    input  logic                             UNDERFLOW_CLR,
    output logic                             FRAME_SYNC,
    input  logic                             TEST_PATTERN
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_RUN        = 2'd2,
        ST_BLANK      = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    fs_d_r;
    logic                    fs_rise_s;
    logic                    rd_d_r;
    logic                    underflow_s;
    logic                    tp_active_s;
    logic [C_DATA_WIDTH-1:0] tp_pix_s;

    // A frame start is a registered 0->1 edge; the register resets to 0 so a
    // high level seen right after reset counts as an edge.
    assign fs_rise_s = FRAME_START_IN & ~fs_d_r;

`ifdef GSLCD_TEST_PATTERN_EN
    localparam int C_COMP_W    = C_DATA_WIDTH / 3;
    localparam int C_BAR_CNT_W = (C_BAR_WIDTH > 1) ? $clog2(C_BAR_WIDTH) : 1;

    logic                   tp_mode_r;
    logic                   act_d_r;
    logic [C_BAR_CNT_W-1:0] bar_px_r;
    logic [2:0]             bar_idx_r;

    // Bar index to colour: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [C_DATA_WIDTH-1:0] bar_colour(input logic [2:0] idx);
        logic [2:0]              rgb;
        logic [C_DATA_WIDTH-1:0] c;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        c = '0;
        c[C_DATA_WIDTH-1 -: C_COMP_W] = {C_COMP_W{rgb[2]}};
        c[2*C_COMP_W-1 -: C_COMP_W]   = {C_COMP_W{rgb[1]}};
        c[C_COMP_W-1 -: C_COMP_W]     = {C_COMP_W{rgb[0]}};
        return c;
    endfunction

    // Latch the pattern request only at frame start so a frame never switches source mid-way.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            tp_mode_r <= 1'b0;
        end else if (fs_rise_s) begin
            tp_mode_r <= TEST_PATTERN;
        end
    end

    // Column position as (bar index, pixel within bar); restarts when ACTIVE_IN falls.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            act_d_r   <= 1'b0;
            bar_px_r  <= '0;
            bar_idx_r <= 3'd0;
        end else begin
            act_d_r <= ACTIVE_IN;
            if (act_d_r && !ACTIVE_IN) begin
                bar_px_r  <= '0;
                bar_idx_r <= 3'd0;
            end else if (ACTIVE_IN) begin
                if (bar_px_r == C_BAR_CNT_W'(C_BAR_WIDTH - 1)) begin
                    bar_px_r <= '0;
                    if (bar_idx_r != 3'd7) begin
                        bar_idx_r <= bar_idx_r + 3'd1;
                    end
                end else begin
                    bar_px_r <= bar_px_r + C_BAR_CNT_W'(1);
                end
            end
        end
    end

    assign tp_active_s = tp_mode_r & (state_r == ST_RUN);
    assign tp_pix_s    = bar_colour(bar_idx_r);
`else
    logic tp_unused_s;
    localparam int C_BAR_UNUSED = C_BAR_WIDTH;

    assign tp_unused_s = TEST_PATTERN;
    assign tp_active_s = 1'b0;
    assign tp_pix_s    = '0;
`endif

    // State register.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, FIFO read strobe and underflow detect.
    always_comb begin
        state_nxt_s = state_r;
        underflow_s = 1'b0;
        FIFO_RD_EN  = 1'b0;
        if ((state_r == ST_RUN) && RD_ACTIVE_IN && !tp_active_s) begin
            underflow_s = FIFO_EMPTY;
            FIFO_RD_EN  = ~FIFO_EMPTY;
        end else begin
            underflow_s = 1'b0;
            FIFO_RD_EN  = 1'b0;
        end
        if (!EN) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:       state_nxt_s = ST_WAIT_FRAME;
                ST_WAIT_FRAME: state_nxt_s = fs_rise_s ? ST_RUN : ST_WAIT_FRAME;
                ST_RUN:        state_nxt_s = underflow_s ? ST_BLANK : ST_RUN;
                ST_BLANK:      state_nxt_s = fs_rise_s ? ST_RUN : ST_BLANK;
                default:       state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Edge detect, read-issued delay and the frame-start pulse to upstream DMA.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            fs_d_r     <= 1'b0;
            rd_d_r     <= 1'b0;
            FRAME_SYNC <= 1'b0;
        end else begin
            fs_d_r     <= FRAME_START_IN;
            rd_d_r     <= FIFO_RD_EN;
            FRAME_SYNC <= EN & fs_rise_s;
        end
    end

    // LCD outputs: timing delayed one PCLK, black unless a pixel was fetched, all zero when disabled.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            LCD_DE    <= 1'b0;
            LCD_VSYNC <= 1'b0;
            LCD_HSYNC <= 1'b0;
            LCD_DATA  <= '0;
        end else if (!EN || (state_r == ST_IDLE)) begin
            LCD_DE    <= 1'b0;
            LCD_VSYNC <= 1'b0;
            LCD_HSYNC <= 1'b0;
            LCD_DATA  <= '0;
        end else begin
            LCD_DE    <= ACTIVE_IN;
            LCD_VSYNC <= VSYNC_IN;
            LCD_HSYNC <= HSYNC_IN;
            if (ACTIVE_IN && tp_active_s) begin
                LCD_DATA <= tp_pix_s;
            end else if (ACTIVE_IN && rd_d_r) begin
                LCD_DATA <= FIFO_DATA;
            end else begin
                LCD_DATA <= '0;
            end
        end
    end

    // Sticky underflow flag (an event beats a clear) and saturating event counter.
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            UNDERFLOW     <= 1'b0;
            UNDERFLOW_CNT <= '0;
        end else begin
            if (underflow_s) begin
                UNDERFLOW <= 1'b1;
            end else if (UNDERFLOW_CLR) begin
                UNDERFLOW <= 1'b0;
            end
            if (underflow_s && (UNDERFLOW_CNT != '1)) begin
                UNDERFLOW_CNT <= UNDERFLOW_CNT + C_UNDERFLOW_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_gslcd_v1_0_pixel_out.sv
// Directed bench for gslcd_v1_0_pixel_out. A ramp FIFO model supplies 0,1,2...
// A second instance with a 4-bit underflow counter shares all inputs so that
// counter saturation is reached in a few events.
module tb_gslcd_v1_0_pixel_out;

    localparam int DW = 24;

    logic          pclk = 1'b0;
    logic          resetn;
    logic          en;
    logic          vsync_in;
    logic          hsync_in;
    logic          active_in;
    logic          rd_active_in;
    logic          frame_start_in;
    logic [DW-1:0] fifo_data = '0;
    logic [DW-1:0] fifo_ptr  = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] lcd_data;
    logic          lcd_vsync;
    logic          lcd_hsync;
    logic          lcd_de;
    logic          underflow;
    logic [15:0]   underflow_cnt;
    logic          underflow_clr;
    logic          frame_sync;
    logic          test_pattern;

    logic          s_fifo_rd_en;
    logic [DW-1:0] s_lcd_data;
    logic          s_lcd_vsync;
    logic          s_lcd_hsync;
    logic          s_lcd_de;
    logic          s_underflow;
    logic [3:0]    s_underflow_cnt;
    logic          s_frame_sync;

    int            checks = 0;
    int            errors = 0;
    int            reads;
    logic          run_exp;
    logic          prev_rd;
    logic [DW-1:0] prev_val;
    logic [DW-1:0] exp_pix;

    gslcd_v1_0_pixel_out #(.C_DATA_WIDTH(DW), .C_UNDERFLOW_CNT_WIDTH(16), .C_BAR_WIDTH(100)) dut (
        .PCLK(pclk), .RESETN(resetn), .EN(en),
        .VSYNC_IN(vsync_in), .HSYNC_IN(hsync_in), .ACTIVE_IN(active_in),
        .RD_ACTIVE_IN(rd_active_in), .FRAME_START_IN(frame_start_in),
        .FIFO_DATA(fifo_data), .FIFO_EMPTY(fifo_empty), .FIFO_RD_EN(fifo_rd_en),
        .LCD_DATA(lcd_data), .LCD_VSYNC(lcd_vsync), .LCD_HSYNC(lcd_hsync), .LCD_DE(lcd_de),
        .UNDERFLOW(underflow), .UNDERFLOW_CNT(underflow_cnt), .UNDERFLOW_CLR(underflow_clr),
        .FRAME_SYNC(frame_sync), .TEST_PATTERN(test_pattern)
    );

    gslcd_v1_0_pixel_out #(.C_DATA_WIDTH(DW), .C_UNDERFLOW_CNT_WIDTH(4), .C_BAR_WIDTH(100)) dut_small (
        .PCLK(pclk), .RESETN(resetn), .EN(en),
        .VSYNC_IN(vsync_in), .HSYNC_IN(hsync_in), .ACTIVE_IN(active_in),
        .RD_ACTIVE_IN(rd_active_in), .FRAME_START_IN(frame_start_in),
        .FIFO_DATA(fifo_data), .FIFO_EMPTY(fifo_empty), .FIFO_RD_EN(s_fifo_rd_en),
        .LCD_DATA(s_lcd_data), .LCD_VSYNC(s_lcd_vsync), .LCD_HSYNC(s_lcd_hsync), .LCD_DE(s_lcd_de),
        .UNDERFLOW(s_underflow), .UNDERFLOW_CNT(s_underflow_cnt), .UNDERFLOW_CLR(underflow_clr),
        .FRAME_SYNC(s_frame_sync), .TEST_PATTERN(test_pattern)
    );

    // Pixel clock.
    always #5 pclk = ~pclk;

    // Ramp FIFO: data appears one cycle after the read strobe.
    always @(posedge pclk) begin
        if (fifo_rd_en) begin
            fifo_data <= fifo_ptr;
            fifo_ptr  <= fifo_ptr + 24'd1;
        end
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic rd, input logic act,
                         input logic emp, input logic hs, input logic vs);
        frame_start_in = fs;
        rd_active_in   = rd;
        active_in      = act;
        fifo_empty     = emp;
        hsync_in       = hs;
        vsync_in       = vs;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One frame-start pulse; expect a single FRAME_SYNC cycle and RUN afterwards.
    task automatic frame_start();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("frame_sync", frame_sync, 1'b1);
        check_eq("lcd_vsync", lcd_vsync, 1'b1);
        run_exp = 1'b1;
        prev_rd = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("frame_sync_off", frame_sync, 1'b0);
    endtask

    // One line of n pixels; RD_ACTIVE leads ACTIVE by one cycle. FIFO goes
    // empty from read slot empty_at onward (negative = never).
    task automatic line(input int n, input int empty_at);
        for (int i = 0; i <= n; i++) begin
            logic          rd;
            logic          act;
            logic          emp;
            logic          exp_rd;
            logic [DW-1:0] exp_d;
            rd  = (i < n);
            act = (i >= 1);
            emp = (empty_at >= 0) && (i >= empty_at);
            drive(1'b0, rd, act, emp, (i == n), 1'b0);
            #1;
            exp_rd = rd && !emp && run_exp;
            check_eq("rd_en", fifo_rd_en, exp_rd);
            check_eq("s_rd_en", s_fifo_rd_en, exp_rd);
            if (fifo_rd_en) reads++;
            exp_d = (act && prev_rd) ? prev_val : '0;
            if (rd && emp && run_exp) run_exp = 1'b0;
            prev_rd  = exp_rd;
            prev_val = exp_pix;
            if (exp_rd) exp_pix = exp_pix + 24'd1;
            tick();
            check_eq("lcd_de", lcd_de, act);
            check_eq("lcd_hsync", lcd_hsync, (i == n));
            check_eq("lcd_data", lcd_data, exp_d);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        en            = 1'b0;
        underflow_clr = 1'b0;
        test_pattern  = 1'b0;
        run_exp       = 1'b0;
        prev_rd       = 1'b0;
        prev_val      = '0;
        exp_pix       = '0;
        reads         = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge pclk);
        #1;
        // Reset state.
        check_eq("rst_rd_en", fifo_rd_en, 1'b0);
        check_eq("rst_de", lcd_de, 1'b0);
        check_eq("rst_vsync", lcd_vsync, 1'b0);
        check_eq("rst_hsync", lcd_hsync, 1'b0);
        check_eq("rst_data", lcd_data, 24'h0);
        check_eq("rst_uf", underflow, 1'b0);
        check_eq("rst_uf_cnt", underflow_cnt, 16'h0);
        check_eq("rst_fsync", frame_sync, 1'b0);

        // Leave reset enabled: WAIT_FRAME shows timing but black and no reads.
        resetn = 1'b1;
        en     = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        line(4, -1);

        // Normal frame with ramp data.
`ifndef GSLCD_TEST_PATTERN_EN
        test_pattern = 1'b1;
`endif
        frame_start();
        reads = 0;
        repeat (3) line(12, -1);
        check_eq("frame_reads", reads, 32'd36);
        test_pattern = 1'b0;

        // Underflow at the 10th pixel of line 50, then blank until next frame.
        frame_start();
        check_eq("uf_pre", underflow, 1'b0);
        for (int l = 0; l < 50; l++) line(12, (l == 49) ? 9 : -1);
        check_eq("uf_flag", underflow, 1'b1);
        check_eq("uf_cnt1", underflow_cnt, 16'd1);
        line(12, -1);
        line(12, -1);
        check_eq("uf_cnt_blank", underflow_cnt, 16'd1);
        frame_start();
        line(12, -1);

        // Many events: small counter saturates; set beats clear.
        for (int k = 0; k < 18; k++) begin
            frame_start();
            line(1, 0);
        end
        frame_start();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        underflow_clr = 1'b1;
        #1;
        check_eq("uf_evt_rd_en", fifo_rd_en, 1'b0);
        run_exp = 1'b0;
        tick();
        check_eq("uf_set_wins", underflow, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("uf_cleared", underflow, 1'b0);
        underflow_clr = 1'b0;
        check_eq("uf_cnt20", underflow_cnt, 16'd20);
        check_eq("uf_cnt_sat", s_underflow_cnt, 4'hF);
        check_eq("uf_flag_small", s_underflow, 1'b0);

        // Reset in the middle of an active line.
        frame_start();
        line(5, -1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("pre_rst_rd_en", fifo_rd_en, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_rd_en", fifo_rd_en, 1'b0);
        check_eq("mid_rst_de", lcd_de, 1'b0);
        check_eq("mid_rst_data", lcd_data, 24'h0);
        check_eq("mid_rst_uf_cnt", underflow_cnt, 16'h0);
        check_eq("mid_rst_s_uf_cnt", s_underflow_cnt, 4'h0);
        run_exp = 1'b0;
        prev_rd = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        #1;
        check_eq("post_rst_rd_en", fifo_rd_en, 1'b0);
        tick();
        check_eq("post_rst_de_idle", lcd_de, 1'b0);
        line(6, -1);
        frame_start();
        line(6, -1);

        // Drop EN mid-line: IDLE next cycle, LCD outputs zero.
        line(4, -1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        en = 1'b0;
        tick();
        check_eq("en_off_de", lcd_de, 1'b0);
        check_eq("en_off_vsync", lcd_vsync, 1'b0);
        check_eq("en_off_data", lcd_data, 24'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("en_off_rd_en", fifo_rd_en, 1'b0);
        run_exp = 1'b0;
        prev_rd = 1'b0;
        tick();
        check_eq("en_off_de2", lcd_de, 1'b0);
        en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        line(4, -1);
        frame_start();
        line(4, -1);

`ifdef GSLCD_TEST_PATTERN_EN
        // Colour bars: no FIFO reads, bar colours at pixels 0, 100 and 700.
        test_pattern = 1'b1;
        frame_start();
        reads = 0;
        for (int i = 0; i <= 800; i++) begin
            drive(1'b0, (i < 800), (i >= 1), 1'b0, 1'b0, 1'b0);
            #1;
            if (fifo_rd_en) reads++;
            tick();
            if (i == 1)   check_eq("tp_px0", lcd_data, 24'hFFFFFF);
            if (i == 101) check_eq("tp_px100", lcd_data, 24'hFFFF00);
            if (i == 701) check_eq("tp_px700", lcd_data, 24'h000000);
        end
        check_eq("tp_reads", reads, 32'd0);
        check_eq("tp_no_uf", underflow, 1'b0);
        test_pattern = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        frame_start();
        line(4, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
